// File: rtl/compare_pkg.sv
// Shared constants and state encoding for the comparator self-test sweep driver.
package compare_pkg;

  localparam int DEF_WIDTH  = 5;
  localparam int DEF_SETTLE = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SETTLE = ST_SETTLE,
    S_CHECK  = ST_CHECK,
    S_DONE   = ST_DONE
  } state_t;

endpackage

// File: rtl/compare_expect.sv
// Combinational golden reference: the relation a correct magnitude comparator must report.
module compare_expect #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             exp_s,
  output logic             exp_ab,
  output logic             exp_bb
);

  assign exp_s  = (a == b);
  assign exp_ab = (a > b);
  assign exp_bb = (a < b);

endmodule

// File: rtl/compare_sweep_driver.sv
// Self-test sequencer: walks every (A,B) operand pair through an external comparator,
// waits a settle time, then checks S/Ab/Bb and records mismatches.
module compare_sweep_driver
  import compare_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  input  logic               s_in,
  input  logic               ab_in,
  input  logic               bb_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   first_fail_a,
  output logic [WIDTH-1:0]   first_fail_b
);

  localparam int CW = 2 * WIDTH;
  localparam int EW = 2 * WIDTH + 1;
  localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SW-1:0]      settle_q, settle_d;
  logic [EW-1:0]      err_q, err_d;
  logic               fail_valid_q, fail_valid_d;
  logic [WIDTH-1:0]   ffa_q, ffa_d;
  logic [WIDTH-1:0]   ffb_q, ffb_d;

  logic exp_s, exp_ab, exp_bb;
  logic mismatch;

  compare_expect #(.WIDTH(WIDTH)) u_expect (
    .a      (a_out),
    .b      (b_out),
    .exp_s  (exp_s),
    .exp_ab (exp_ab),
    .exp_bb (exp_bb)
  );

  // Any disagreement counts, including responses that are not one-hot.
  assign mismatch = ({s_in, ab_in, bb_in} != {exp_s, exp_ab, exp_bb});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      settle_q     <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      ffa_q        <= '0;
      ffb_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      settle_q     <= settle_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      ffa_q        <= ffa_d;
      ffb_q        <= ffb_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    settle_d     = settle_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    ffa_d        = ffa_q;
    ffb_d        = ffb_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_SETTLE;
          cnt_d        = '0;
          settle_d     = SW'(SETTLE);
          err_d        = '0;
          fail_valid_d = 1'b0;
          ffa_d        = '0;
          ffb_d        = '0;
        end
      end
      S_SETTLE: begin
        settle_d = settle_q - SW'(1);
        if (settle_q <= SW'(1)) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_q != {EW{1'b1}}) err_d = err_q + EW'(1);
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            ffa_d        = a_out;
            ffb_d        = b_out;
          end
        end
        // The final pair leaves the operands parked at all-ones.
        if (cnt_q == {CW{1'b1}}) begin
          state_d = S_DONE;
        end else begin
          cnt_d    = cnt_q + CW'(1);
          settle_d = SW'(SETTLE);
          state_d  = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign a_out        = cnt_q[CW-1:WIDTH];
  assign b_out        = cnt_q[WIDTH-1:0];
  assign busy         = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done         = (state_q == S_DONE);
  assign pass         = done && (err_q == '0);
  assign err_count    = err_q;
  assign fail_valid   = fail_valid_q;
  assign first_fail_a = ffa_q;
  assign first_fail_b = ffb_q;

endmodule

// File: tb/tb_compare_sweep_driver.sv
// Bench for compare_sweep_driver: attaches behavioural comparators (good and faulty)
// and checks each sweep's results against an exhaustive reference computed here.
module tb_compare_sweep_driver;

  localparam int W      = 5;
  localparam int NPAIR  = 1 << (2 * W);
  localparam int BUSYN  = NPAIR * 3;

  logic            clk = 1'b0;
  logic            clk_en = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [W-1:0]    a_out, b_out;
  logic            s_in, ab_in, bb_in;
  logic            busy, done, pass, fail_valid;
  logic [2*W:0]    err_count;
  logic [W-1:0]    first_fail_a, first_fail_b;

  int compared = 0;
  int mismatched = 0;
  int mode = 0;
  logic [2:0] flip [NPAIR];

  compare_sweep_driver dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .a_out        (a_out),
    .b_out        (b_out),
    .s_in         (s_in),
    .ab_in        (ab_in),
    .bb_in        (bb_in),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_count    (err_count),
    .fail_valid   (fail_valid),
    .first_fail_a (first_fail_a),
    .first_fail_b (first_fail_b)
  );

  always #5 if (clk_en) clk = ~clk;

  // Comparator under test: 0 good, 1 Ab/Bb swapped, 2 S stuck at 0, 3 random per-pair faults.
  function automatic logic [2:0] model_resp(input int m, input int a, input int b);
    logic [2:0] good;
    good = {a == b, a > b, a < b};
    case (m)
      1:       return {a == b, a < b, a > b};
      2:       return {1'b0, a > b, a < b};
      3:       return good ^ flip[a * (1 << W) + b];
      default: return good;
    endcase
  endfunction

  always_comb {s_in, ab_in, bb_in} = model_resp(mode, int'(a_out), int'(b_out));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, a_out, 0);
    check({tag, "_b"}, b_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_fv"}, fail_valid, 0);
    check({tag, "_ffa"}, first_fail_a, 0);
    check({tag, "_ffb"}, first_fail_b, 0);
  endtask

  // Exhaustive reference in sweep order (B fastest).
  task automatic compute_expected(input int m, output int e_err, output bit e_fv,
                                  output int e_fa, output int e_fb);
    e_err = 0; e_fv = 0; e_fa = 0; e_fb = 0;
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        if (model_resp(m, a, b) != {a == b, a > b, a < b}) begin
          if (e_err < (1 << (2 * W + 1)) - 1) e_err++;
          if (!e_fv) begin
            e_fv = 1; e_fa = a; e_fb = b;
          end
        end
      end
    end
  endtask

  task automatic randomize_faults();
    for (int i = 0; i < NPAIR; i++)
      flip[i] = ($urandom_range(0, 31) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
  endtask

  task automatic applyStimulus(input int m, input int ignore_at, input int reset_at);
    int  e_err, e_fa, e_fb, nbusy;
    bit  e_fv, aborted;
    mode = m;
    compute_expected(m, e_err, e_fv, e_fa, e_fb);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_done_clr", done, 0);
    check("start_err_clr", err_count, 0);
    check("start_fv_clr", fail_valid, 0);
    check("start_a0", a_out, 0);
    check("start_b0", b_out, 0);
    nbusy = 0;
    aborted = 0;
    while (busy && nbusy < BUSYN + 1000 && !aborted) begin
      nbusy++;
      start = (nbusy == ignore_at);
      if (nbusy == reset_at) begin
        rst = 1'b1;
        #1 check_all_zero("rst_mid");
        @(negedge clk);
        @(negedge clk);
        check_all_zero("rst_hold");
        rst = 1'b0;
        aborted = 1;
      end else begin
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!aborted) checkOutput(nbusy, e_err, e_fv, e_fa, e_fb);
  endtask

  task automatic checkOutput(input int nbusy, input int e_err, input bit e_fv,
                             input int e_fa, input int e_fb);
    check("busy_cycles", nbusy, BUSYN);
    check("done", done, 1);
    check("pass", pass, (e_err == 0));
    check("err_count", err_count, e_err);
    check("fail_valid", fail_valid, e_fv);
    check("first_fail_a", first_fail_a, e_fa);
    check("first_fail_b", first_fail_b, e_fb);
    check("a_hold", a_out, (1 << W) - 1);
    check("b_hold", b_out, (1 << W) - 1);
    @(negedge clk);
    check("done_held", done, 1);
    check("err_held", err_count, e_err);
  endtask

  initial begin
    // Asynchronous reset with the clock stopped.
    #1 rst = 1'b1;
    #2 check_all_zero("rst_noclk");
    #20 check_all_zero("rst_noclk_hold");
    clk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    $display("[TB] good comparator");
    applyStimulus(0, 0, 0);
    $display("[TB] Ab/Bb swapped");
    applyStimulus(1, 0, 0);
    $display("[TB] S stuck at 0");
    applyStimulus(2, 0, 0);
    $display("[TB] reset mid-sweep then good sweep");
    applyStimulus(0, 0, 100);
    @(negedge clk);
    applyStimulus(0, 0, 0);
    $display("[TB] start while busy ignored, then restart from DONE");
    applyStimulus(0, 10, 0);
    applyStimulus(2, 0, 0);
    $display("[TB] random per-pair faults");
    randomize_faults();
    applyStimulus(3, 0, 0);
    randomize_faults();
    applyStimulus(3, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
